// File: rtl/bcd_pkg.sv
// Shared constants and state encoding for the BCD <-> binary conversion paths.
// Both directions import this package so digit and word widths stay consistent.
package bcd_pkg;

    localparam int BCD_DIGITS    = 3;
    localparam int BIN_W         = 12;
    localparam int BCD_MAX_DIGIT = 9;
    localparam int DABBLE_ADJ    = 3;
    localparam int DIGIT_W       = 4;
    localparam int ADJ_THRESHOLD = 8;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    function automatic logic digit_valid(input logic [DIGIT_W-1:0] digit);
        return digit <= DIGIT_W'(BCD_MAX_DIGIT);
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble nibble correction: after each right shift, a BCD
// nibble that reached 8 or more has picked up a borrowed 10/2, so remove 3.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [DIGIT_W-1:0] adjusted
);

    assign adjusted = (digit >= DIGIT_W'(ADJ_THRESHOLD)) ? digit - DIGIT_W'(DABBLE_ADJ)
                                                          : digit;

endmodule

// File: rtl/bcd_2_bin.sv
// Sequential three-digit BCD to 12-bit binary converter (reverse double-dabble)
// with a start/busy/done handshake between digit entry and the binary datapath.
module bcd_2_bin
    import bcd_pkg::ST_IDLE;
    import bcd_pkg::ST_SHIFT;
    import bcd_pkg::ST_DONE;
    import bcd_pkg::state_t;
    import bcd_pkg::DIGIT_W;
    import bcd_pkg::digit_valid;
#(
    parameter int NUM_DIGITS = 3,
    parameter int BIN_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       huns,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BIN_W-1:0] bin
);

    localparam int SR_W  = NUM_DIGITS * DIGIT_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [SR_W-1:0]    shift_reg;
    logic [SR_W-1:0]    shifted;
    logic [SR_W-1:0]    next_reg;
    logic [DIGIT_W-1:0] adj_nib [NUM_DIGITS];
    logic               all_valid;

    assign all_valid = digit_valid(huns) && digit_valid(tens) && digit_valid(ones);
    assign shifted   = shift_reg >> 1;

    // The BCD nibbles sit above the binary field; each is corrected after the shift.
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (shifted[BIN_W + DIGIT_W*g +: DIGIT_W]),
            .adjusted (adj_nib[g])
        );
    end

    always_comb begin
        next_reg = shifted;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            next_reg[BIN_W + DIGIT_W*i +: DIGIT_W] = adj_nib[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            shift_reg <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            bin       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (!all_valid) begin
                            err   <= 1'b1;
                            bin   <= '0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            shift_reg <= {huns, tens, ones, {BIN_W{1'b0}}};
                            count     <= '0;
                            busy      <= 1'b1;
                            state     <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= next_reg;
                    count     <= count + 1'b1;
                    // Last iteration: the binary field of the corrected register is the result.
                    if (count == CNT_W'(BIN_W - 1)) begin
                        bin   <= next_reg[BIN_W-1:0];
                        err   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_2_bin.sv
// Self-checking bench for bcd_2_bin: vector table plus hand sequences, with a
// scoreboard queue that is matched against every done pulse.
module tb_bcd_2_bin;

    typedef struct {
        logic [3:0]  h;
        logic [3:0]  t;
        logic [3:0]  o;
        logic [11:0] bin;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  huns = '0;
    logic [3:0]  tens = '0;
    logic [3:0]  ones = '0;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] bin;

    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t exp_q[$];
    vec_t mon_e;
    vec_t tbl[8];

    bcd_2_bin #(.NUM_DIGITS(3), .BIN_W(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .huns  (huns),
        .tens  (tens),
        .ones  (ones),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .bin   (bin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done) begin
            check("busy_with_done", int'(busy), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("bin", int'(bin), int'(mon_e.bin));
                check("err", int'(err), int'(mon_e.err));
            end
        end
    end

    task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                           input logic [11:0] eb, input logic ee, input bit timing);
        int busy_n;
        int done_at;
        busy_n  = 0;
        done_at = 0;
        exp_q.push_back('{h, t, o, eb, ee});
        @(negedge clk);
        huns  = h;
        tens  = t;
        ones  = o;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        huns  = 4'($urandom_range(0, 15));
        tens  = 4'($urandom_range(0, 15));
        ones  = 4'($urandom_range(0, 15));
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (busy) busy_n++;
            if (done) begin
                done_at = c;
                break;
            end
        end
        if (timing) check("busy_cycles", busy_n, ee ? 0 : 12);
        check("done_latency", done_at, ee ? 1 : 13);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n_done;
        int done_at;

        tbl[0] = '{4'd9, 4'd9, 4'd9, 12'h3E7, 1'b0};
        tbl[1] = '{4'd0, 4'd0, 4'd0, 12'h000, 1'b0};
        tbl[2] = '{4'd2, 4'd5, 4'd5, 12'h0FF, 1'b0};
        tbl[3] = '{4'd1, 4'd0, 4'd0, 12'h064, 1'b0};
        tbl[4] = '{4'd4, 4'hA, 4'd1, 12'h000, 1'b1};
        tbl[5] = '{4'd0, 4'd4, 4'd2, 12'h02A, 1'b0};
        tbl[6] = '{4'd9, 4'd0, 4'hF, 12'h000, 1'b1};
        tbl[7] = '{4'd8, 4'd8, 4'd8, 12'h378, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err",  int'(err),  0);
        check("rst_bin",  int'(bin),  0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            convert(tbl[i].h, tbl[i].t, tbl[i].o, tbl[i].bin, tbl[i].err, 1'b1);
        end

        // Extra start pulses during SHIFT and DONE must neither queue nor restart.
        exp_q.push_back('{4'd1, 4'd2, 4'd3, 12'h07B, 1'b0});
        n_done  = 0;
        done_at = 0;
        huns  = 4'd1;
        tens  = 4'd2;
        ones  = 4'd3;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                if (done_at == 0) done_at = c;
            end
            start = (c == 3 || c == 12 || c == 13);
            huns  = 4'd9;
            tens  = 4'd9;
            ones  = 4'd9;
        end
        start = 1'b0;
        check("ignored_start_dones", n_done, 1);
        check("ignored_start_latency", done_at, 13);

        // Reset in the middle of a conversion aborts it without a done pulse.
        @(negedge clk);
        huns  = 4'd5;
        tens  = 4'd0;
        ones  = 4'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_bin",  int'(bin),  0);
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", n_done, 0);
        convert(4'd5, 4'd0, 4'd0, 12'h1F4, 1'b0, 1'b1);

        for (int v = 0; v < 1000; v++) begin
            convert(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), 12'(v), 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_2_bin.md
Name: bcd_2_bin

Overview:
Sequential BCD-to-binary converter. It is the inverse of the team's combinational binary-to-BCD path and uses reverse double-dabble: shift right, then subtract 3 from each BCD nibble that is 8 or more. It takes three BCD digits (000–999) and returns a 12-bit binary value after a fixed multi-cycle latency, using a start/busy/done handshake. It sits between the keypad/7-segment digit-entry logic and the 12-bit binary datapath.

Parameters:
- NUM_DIGITS, 3, number of BCD input digits (fixed at 3 for this revision)
- BIN_W, 12, binary output width and number of shift iterations

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request conversion; sampled only in IDLE
- huns  input  4  hundreds BCD digit
- tens  input  4  tens BCD digit
- ones  input  4  ones BCD digit
- busy  output  1  high while a conversion is in progress (SHIFT state)
- done  output  1  one-cycle pulse when bin/err are updated
- err  output  1  set when the last request had a digit > 9; held until the next completion
- bin  output  12  converted value; held until the next completion

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; busy=0, done=0, err=0, bin=0; shift register and counter cleared. Reset wins over every other input, including mid-conversion. An aborted conversion produces no done pulse.
- State IDLE: if start=1, sample huns/tens/ones.
  - Any digit > 9: next state DONE with err=1, bin=0.
  - All digits valid: load the 24-bit shift register {huns,tens,ones,12'b0}, set counter=0, busy=1, next state SHIFT.
- State SHIFT, one iteration per clock:
  - Shift the whole register right by 1.
  - Then, independently for each of the three nibbles, if nibble >= 8, subtract 3 (via bcd_digit_adjust).
  - Counter increments each iteration. After iteration BIN_W (counter == BIN_W-1 at the edge): latch bin = register[11:0], err=0, busy=0, next state DONE.
- State DONE: done=1 for exactly this cycle, then unconditionally IDLE. start is ignored in DONE.
- Latency, valid input: start sampled at edge E; busy high from E+1 through E+12; done=1 and new bin visible from E+13 for one cycle.
- Latency, invalid input: done=1 and err=1 visible from E+1.
- Minimum start-to-start spacing is 14 cycles.
- start=1 while busy or in DONE is ignored: no queuing, no restart.
- Inputs may change after the sampling edge without affecting the result.
- Arithmetic: all values are unsigned. The maximum result is 999 (0x3E7), so bin[11:10] are always 0 for valid input. Nibble correction never underflows, because it is only applied when the nibble is >= 8.
- busy and done are never high in the same cycle.

Decomposition:
- Shared package bcd_pkg:
  - constants BCD_DIGITS=3, BIN_W=12, BCD_MAX_DIGIT=9, DABBLE_ADJ=3
  - state enumeration IDLE/SHIFT/DONE (2-bit encoding)
  - shared with the binary-to-BCD side so widths stay consistent.
- One combinational sub-module, bcd_digit_adjust: 4-bit in / 4-bit out, output = in−3 if in ≥ 8, else in. Instantiate it three times, one per nibble.
- The controller FSM, counter and shift register live in bcd_2_bin.

Test Plan:
- Reset, then start with huns=9, tens=9, ones=9 → done pulse 13 cycles after the sampling edge; bin=0x3E7; err=0; busy high for exactly 12 cycles.
- Start with 0,0,0 → bin=0x000 after 13 cycles. Then start with 2,5,5 → bin=0x0FF. Then start with 1,0,0 → bin=0x064.
- Start with huns=4, tens=0xA, ones=1 → next cycle done=1, err=1, bin=0, busy never asserts. A following valid request with 0,4,2 → bin=0x02A, err cleared.
- Start with 1,2,3; pulse start again with 9,9,9 at cycles 3, 12 and 13 after acceptance → single done; bin=0x07B; no second conversion until IDLE.
- Start with 5,0,0, assert rst at cycle 6 of SHIFT → next cycle state IDLE, busy=0, bin=0, no done. A fresh start with 5,0,0 → bin=0x1F4.
- Exhaustive round trip: drive every value 0–999 through the binary-to-BCD converter into bcd_2_bin → bin equals the original value and err=0 for all 1000 cases.
